// File: rtl/arb_pkg.sv
// Shared types and defaults for the CPU/DMA data-memory arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_state_t;

    localparam int ARB_STARVE_LIMIT = 8;
    localparam int ARB_MAX_BURST    = 4;
    localparam int WAIT_W           = 4;
    localparam int BURST_W          = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage and a DMA engine, with
// starvation forcing for the DMA and locked DMA bursts.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   ARB_CPU | default; CPU wins unless the DMA has waited STARVE_LIMIT cycles
//   ARB_DMA | locked DMA burst in progress; CPU is stalled
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int MAX_BURST    = ARB_MAX_BURST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_t          state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [BURST_W-1:0]  burst_cnt, burst_nxt;
    logic                starve;
    logic                cpu_served;
    logic                dma_served;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_CPU;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Grant is qualified by reset so nothing reaches memory while it is asserted.
    always_comb begin
        starve     = dma_req && (wait_cnt == WAIT_W'(STARVE_LIMIT));
        cpu_served = 1'b0;
        dma_served = 1'b0;
        if (reset) begin
            if (state == ARB_CPU) begin
                cpu_served = cpu_req && !starve;
                dma_served = dma_req && !cpu_served;
            end else begin
                dma_served = dma_req;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        case (state)
            ARB_CPU: begin
                if (dma_served && dma_lock && (MAX_BURST > 1)) begin
                    state_nxt = ARB_DMA;
                    burst_nxt = BURST_W'(1);
                end
            end
            ARB_DMA: begin
                if (!dma_req || !dma_lock ||
                    (burst_cnt + BURST_W'(1) == BURST_W'(MAX_BURST))) begin
                    state_nxt = ARB_CPU;
                    burst_nxt = '0;
                end else begin
                    burst_nxt = burst_cnt + BURST_W'(1);
                end
            end
            default: begin
                state_nxt = ARB_CPU;
                burst_nxt = '0;
            end
        endcase
    end

    always_comb begin
        wait_nxt = '0;
        if (dma_req && !dma_served) begin
            if (wait_cnt == WAIT_W'(STARVE_LIMIT)) wait_nxt = wait_cnt;
            else                                   wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

    // Idle cycles park the address on the CPU so its load path stays warm.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_served) begin
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dma_served) begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_rdata = cpu_served ? mem_rdata : '0;
    assign dma_rdata = dma_served ? mem_rdata : '0;
    assign cpu_stall = reset && cpu_req && !cpu_served;
    assign dma_ack   = dma_served;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle arbitration
// plus hand-written starvation, burst and reset sequences.
module tb_mem_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    logic        load_mem = 1'b1;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_lock  (dma_lock),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word-addressed memory model: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[4] <= 32'h1111_1111;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw, dl;
        logic [31:0] da, dd;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_stall, e_ack;
        logic [31:0] e_crd, e_drd;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic dl,
                         input logic [31:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          cr   cw   ca      cd            dr   dw   dl   da      dd            e_addr  we   e_wdata       st   ack  e_crd         e_drd
        vecs[0] = '{1'b0,1'b0,32'h44,32'h0000_5555,1'b0,1'b0,1'b0,32'h80,32'h0,        32'h44, 1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[1] = '{1'b1,1'b1,32'h10,32'hA5A5_A5A5,1'b0,1'b0,1'b0,32'h80,32'h0,        32'h10, 1'b1,32'hA5A5_A5A5,1'b0,1'b0,32'h1111_1111,32'h0};
        vecs[2] = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,1'b0,32'h80,32'h0,        32'h10, 1'b0,32'h0,        1'b0,1'b0,32'hA5A5_A5A5,32'h0};
        vecs[3] = '{1'b0,1'b0,32'h10,32'h0,        1'b1,1'b1,1'b0,32'h24,32'h1234_5678,32'h24, 1'b1,32'h1234_5678,1'b0,1'b1,32'h0,        32'h0};
        vecs[4] = '{1'b0,1'b0,32'h10,32'h0,        1'b1,1'b0,1'b0,32'h24,32'h0,        32'h24, 1'b0,32'h0,        1'b0,1'b1,32'h0,        32'h1234_5678};
        vecs[5] = '{1'b1,1'b0,32'h10,32'h0,        1'b1,1'b1,1'b0,32'h30,32'h0BAD,     32'h10, 1'b0,32'h0,        1'b0,1'b0,32'hA5A5_A5A5,32'h0};
        vecs[6] = '{1'b0,1'b0,32'h13,32'h0,        1'b0,1'b0,1'b0,32'h30,32'h0,        32'h13, 1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[7] = '{1'b1,1'b1,32'h1B,32'hDEAD_BEEF,1'b0,1'b0,1'b0,32'h30,32'h0,        32'h1B, 1'b1,32'hDEAD_BEEF,1'b0,1'b0,32'h0,        32'h0};
        vecs[8] = '{1'b0,1'b1,32'h08,32'hFFFF_FFFF,1'b0,1'b1,1'b0,32'h30,32'hFFFF_FFFF,32'h08, 1'b0,32'h0,        1'b0,1'b0,32'h0,        32'h0};
        vecs[9] = '{1'b0,1'b0,32'h08,32'h0,        1'b1,1'b0,1'b0,32'h18,32'h0,        32'h18, 1'b0,32'h0,        1'b0,1'b1,32'h0,        32'hDEAD_BEEF};

        // Reset held with every request active: outputs must stay quiet.
        drive(1'b1, 1'b1, 32'h10, 32'h77, 1'b1, 1'b1, 1'b1, 32'h20, 32'h88);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.mem_we",    32'(mem_we), 32'h0);
        check("rst.stall",     32'(cpu_stall), 32'h0);
        check("rst.ack",       32'(dma_ack), 32'h0);
        check("rst.cpu_rdata", cpu_rdata, 32'h0);
        check("rst.dma_rdata", dma_rdata, 32'h0);
        check("rst.state",     32'(dut.state), 32'(ARB_CPU));
        check("rst.wait",      32'(dut.wait_cnt), 32'h0);
        check("rst.burst",     32'(dut.burst_cnt), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #2 load_mem = 1'b0;
        reset = 1'b1;

        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].dr, vecs[i].dw, vecs[i].dl, vecs[i].da, vecs[i].dd);
            @(negedge clk);
            check($sformatf("v%0d.addr", i),  mem_addr, vecs[i].e_addr);
            check($sformatf("v%0d.we", i),    32'(mem_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d.wdata", i), mem_wdata, vecs[i].e_wdata);
            check($sformatf("v%0d.stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d.ack", i),   32'(dma_ack), 32'(vecs[i].e_ack));
            check($sformatf("v%0d.crd", i),   cpu_rdata, vecs[i].e_crd);
            check($sformatf("v%0d.drd", i),   dma_rdata, vecs[i].e_drd);
        end

        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Starvation: CPU wins eight cycles, DMA is forced on the ninth.
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
            @(negedge clk);
            check($sformatf("starve%0d.ack", c),   32'(dma_ack), (c == 9) ? 32'h1 : 32'h0);
            check($sformatf("starve%0d.stall", c), 32'(cpu_stall), (c == 9) ? 32'h1 : 32'h0);
            check($sformatf("starve%0d.addr", c),  mem_addr, (c == 9) ? 32'h24 : 32'h10);
            check($sformatf("starve%0d.crd", c),   cpu_rdata, (c == 9) ? 32'h0 : 32'hA5A5_A5A5);
            check($sformatf("starve%0d.drd", c),   dma_rdata, (c == 9) ? 32'h1234_5678 : 32'h0);
            check($sformatf("starve%0d.wait", c),  32'(dut.wait_cnt), (c == 10) ? 32'h0 : 32'(c - 1));
        end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Full locked burst of four writes; a CPU arriving mid-burst waits until cycle 5.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            drive(k >= 1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'hB0 + 32'(k));
            @(negedge clk);
            check($sformatf("burst%0d.ack", k),   32'(dma_ack), 32'h1);
            check($sformatf("burst%0d.we", k),    32'(mem_we), 32'h1);
            check($sformatf("burst%0d.addr", k),  mem_addr, 32'h20 + 32'(4 * k));
            check($sformatf("burst%0d.stall", k), 32'(cpu_stall), (k >= 1) ? 32'h1 : 32'h0);
            check($sformatf("burst%0d.state", k), 32'(dut.state), (k == 0) ? 32'(ARB_CPU) : 32'(ARB_DMA));
            check($sformatf("burst%0d.cnt", k),   32'(dut.burst_cnt), 32'(k));
        end
        next_cycle();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 32'h30, 32'hB4);
        @(negedge clk);
        check("burst4.state", 32'(dut.state), 32'(ARB_CPU));
        check("burst4.stall", 32'(cpu_stall), 32'h0);
        check("burst4.ack",   32'(dma_ack), 32'h0);
        check("burst4.addr",  mem_addr, 32'h10);
        check("burst4.crd",   cpu_rdata, 32'hA5A5_A5A5);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            check($sformatf("burst.mem%0d", k), mem[8 + k], 32'hB0 + 32'(k));

        // Locked burst abandoned after two beats; counter restarts on re-entry.
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
        @(negedge clk);
        check("drop.b1.ack", 32'(dma_ack), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h24, 32'h0);
        @(negedge clk);
        check("drop.b2.ack", 32'(dma_ack), 32'h1);
        check("drop.b2.cnt", 32'(dut.burst_cnt), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h28, 32'h0);
        @(negedge clk);
        check("drop.idle.ack",   32'(dma_ack), 32'h0);
        check("drop.idle.we",    32'(mem_we), 32'h0);
        check("drop.idle.state", 32'(dut.state), 32'(ARB_DMA));
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h28, 32'h0);
        @(negedge clk);
        check("drop.back.state", 32'(dut.state), 32'(ARB_CPU));
        check("drop.back.cnt",   32'(dut.burst_cnt), 32'h0);
        check("drop.back.ack",   32'(dma_ack), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("drop.reenter.cnt", 32'(dut.burst_cnt), 32'h1);
        next_cycle();

        // Reset during beat 2 of a locked write burst.
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h34, 32'hC0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h3C, 32'hEE, 1'b1, 1'b1, 1'b1, 32'h38, 32'hC1);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstb.we",    32'(mem_we), 32'h0);
        check("rstb.ack",   32'(dma_ack), 32'h0);
        check("rstb.stall", 32'(cpu_stall), 32'h0);
        check("rstb.drd",   dma_rdata, 32'h0);
        check("rstb.state", 32'(dut.state), 32'(ARB_CPU));
        check("rstb.wait",  32'(dut.wait_cnt), 32'h0);
        check("rstb.burst", 32'(dut.burst_cnt), 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rstb.nowrite", mem[14], 32'h0);
        check("rstb.mem13",   mem[13], 32'hC0);
        check("post.state",   32'(dut.state), 32'(ARB_CPU));
        check("post.stall",   32'(cpu_stall), 32'h0);
        check("post.ack",     32'(dma_ack), 32'h0);
        check("post.addr",    mem_addr, 32'h3C);
        check("post.we",      32'(mem_we), 32'h1);
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("post.mem15", mem[15], 32'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, sets the consecutive DMA wait cycles before DMA gets forced priority.
REQ-002 Parameter MAX_BURST, default 4, sets the maximum consecutive locked DMA beats.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_req / cpu_we  input  1 / 1  MEM-stage access request and write enable.
REQ-006 cpu_addr / cpu_wdata  input  32 / 32  MEM-stage byte address and store data.
REQ-007 cpu_rdata / cpu_stall  output  32 / 1  load data and pipeline stall (PC, IF/ID, ID/EX, EX/MEM hold).
REQ-008 dma_req / dma_we / dma_lock  input  1 / 1 / 1  DMA request, write enable and burst-lock request.
REQ-009 dma_addr / dma_wdata  input  32 / 32  DMA byte address and write data.
REQ-010 dma_rdata / dma_ack  output  32 / 1  DMA read data and beat-performed strobe.
REQ-011 mem_addr / mem_we / mem_wdata  output  32 / 1 / 32  data-memory port; memory reads combinationally and writes on the clk edge.
REQ-012 mem_rdata  input  32  data-memory read data.

Function
REQ-013 The FSM SHALL have two states: ARB_CPU (default) and ARB_DMA (locked burst).
REQ-014 In ARB_CPU, the CPU SHALL be served when cpu_req=1, unless dma_req=1 and wait_cnt==STARVE_LIMIT; otherwise the DMA SHALL be served if dma_req=1.
REQ-015 In ARB_CPU, when the DMA is served with dma_lock=1 and MAX_BURST>1, the next state SHALL be ARB_DMA with burst_cnt=1.
REQ-016 In ARB_DMA, the DMA SHALL be served whenever dma_req=1, and burst_cnt SHALL increment per served beat.
REQ-017 ARB_DMA SHALL return to ARB_CPU after a cycle with dma_req=0 or dma_lock=0, or after the beat on which burst_cnt reaches MAX_BURST.
REQ-018 The served requester's addr/we/wdata SHALL drive mem_*, with zero added latency; the read result SHALL be valid in the same cycle.
REQ-019 When nothing is served, mem_we SHALL be 0, mem_addr SHALL be cpu_addr, and mem_wdata SHALL be 0.
REQ-020 cpu_rdata and dma_rdata SHALL equal mem_rdata when their requester is served, and 0 otherwise.
REQ-021 cpu_stall SHALL equal cpu_req AND NOT cpu_served.
REQ-022 dma_ack SHALL equal dma_served.
REQ-023 wait_cnt (4 bit) SHALL increment, saturating at STARVE_LIMIT, each cycle dma_req=1 and the DMA is not served; it SHALL clear when the DMA is served or dma_req=0.
REQ-024 A stalled CPU SHALL hold its request; the arbiter SHALL NOT register CPU data.
REQ-025 mem_addr[1:0] SHALL pass through unchanged; alignment is the memory's concern.
REQ-026 At most one requester SHALL be served per cycle.
REQ-027 mem_we SHALL never be 1 in a cycle with neither cpu_req nor dma_req.

Reset
REQ-028 While reset=0, the state SHALL be ARB_CPU, wait_cnt=0 and burst_cnt=0.
REQ-029 While reset=0, mem_we=0, cpu_stall=0, dma_ack=0, cpu_rdata=0 and dma_rdata=0, regardless of inputs.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no write performed; after release, the first cycle SHALL arbitrate from ARB_CPU.

Structure
REQ-031 Package arb_pkg SHALL hold the state enum (ARB_CPU, ARB_DMA), STARVE_LIMIT, MAX_BURST and the counter widths.
REQ-032 The design SHALL be one module with no sub-module; the FSM, counters and output mux are all local.

Verification
REQ-033 Only cpu_req=1, we=1, addr=0x10, wdata=0xA5A5A5A5 -> mem_we=1 same cycle, cpu_stall=0; a following load returns 0xA5A5A5A5.
REQ-034 cpu_req and dma_req (unlocked) held high for 10 cycles -> CPU served for cycles 1-8, DMA served (dma_ack=1, cpu_stall=1) on cycle 9, wait_cnt=0 on cycle 10.
REQ-035 dma_lock=1, dma_req=1, cpu idle, DMA addr 0x20..0x2C -> 4 acks, then state ARB_CPU; a waiting cpu_req is served in cycle 5.
REQ-036 Locked burst with dma_req dropped after beat 2 -> return to ARB_CPU next cycle, burst_cnt cleared on re-entry.
REQ-037 reset pulled low during burst beat 2, with dma_we=1 -> mem_we=0 immediately; after release, state=ARB_CPU and counters=0.
REQ-038 Neither requester active -> mem_we=0 and dma_ack=0, while mem_addr follows cpu_addr.
